dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
// - Data-memory access controller for the MEM stage. Sits between the EX/MEM register fields
//   (MemRead, MemWrite, Alu_Result, RD_Two, func3) and a word-wide, variable-latency data RAM.
// - Performs byte-lane steering for SB/SH/SW and load extension for LB/LH/LW/LBU/LHU.
// - Drives mem_stall to freeze the pipeline until the RAM acknowledges.
// - Flags misaligned accesses and RAM timeouts.
// PARAMETERS
// - DATA_W      32   data width (fixed at 32; lane logic assumes 4 bytes)
// - DM_ADDRESS  9    byte address width from the ALU result
// - TIMEOUT     15   max cycles waiting for ram_ack before abort (1..255)
// PORTS
// - clk        in   1             single clock, rising edge
// - reset      in   1             synchronous, active-high
// - MemRead    in   1             load request, held stable by pipeline while mem_stall=1
// - MemWrite   in   1             store request, same hold rule
// - addr       in   DM_ADDRESS    byte address
// - wr_data    in   DATA_W        store data (forwarded rs2)
// - func3      in   3             access size / sign
// - rd_data    out  DATA_W        extended load result, registered
// - mem_stall  out  1             1 = hold IF..MEM stages
// - misalign   out  1             1-cycle pulse: misaligned access dropped
// - bus_err    out  1             1-cycle pulse: timeout abort
// - ram_req    out  1             RAM request, held until ram_ack
// - ram_we     out  1             1 = write
// - ram_addr   out  DM_ADDRESS-2  word address (addr[DM_ADDRESS-1:2])
// - ram_be     out  4             byte enables
// - ram_wdata  out  DATA_W        lane-replicated store data
// - ram_rdata  in   DATA_W        RAM read word, valid with ram_ack
// - ram_ack    in   1             RAM completion, may assert in the cycle after ram_req rises
// BEHAVIOUR
// - Reset: state=IDLE. All outputs are 0: rd_data, mem_stall, misalign, bus_err, ram_req, ram_we, ram_be, ram_wdata.
// - FSM states IDLE, ACCESS, DONE.
//   - IDLE, request (MemRead|MemWrite), aligned:
//     - Register we, be, word address and wdata.
//     - ram_req=1; mem_stall=1 combinationally in this same cycle.
//     - Next state ACCESS.
//   - IDLE, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
//     - No RAM access, no stall.
//     - misalign=1 next cycle; rd_data<=0.
//     - Stay in IDLE.
//   - ACCESS: ram_req=1, mem_stall=1.
//     - On ram_ack: for a load, capture the extended ram_rdata into rd_data. Go to DONE.
//     - Wait counter reaches TIMEOUT without ack: drop ram_req, pulse bus_err, rd_data<=0, go to DONE.
//   - DONE: mem_stall=0 (pipeline advances exactly once), ram_req=0. Go to IDLE unconditionally.
//     The held request is therefore never re-issued.
// - MemRead and MemWrite both 1: treated as a store; a load result is not produced.
// - func3 values not listed below with a request: treated as a word access.
// - Store lanes:
//   - SB(000): be=1<<addr[1:0]; wdata={4{wr_data[7:0]}}.
//   - SH(001): be=addr[1]?1100:0011; wdata={2{wr_data[15:0]}}.
//   - SW(010): be=1111.
// - Loads: select the byte/half by addr[1:0]. LB/LH sign-extend; LBU(100)/LHU(101) zero-extend; LW passes the word.
// - Latency: best case request cycle -> ACCESS (ack) -> DONE. 3 cycles of MEM occupancy.
//   mem_stall is high for the first 2 of those cycles.
// - rd_data holds its value until the next completed load, misalign, timeout or reset.
// - Reset mid-access: immediate return to IDLE, ram_req drops in the same edge, and no result is written.
// - ram_ack while in IDLE or DONE is ignored.
// STRUCTURE
// - dmem_pkg: enum dmem_state_e {IDLE, ACCESS, DONE}; localparams F3_B=3'b000, F3_H=3'b001,
//   F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
// - Sub-module lsu_align (combinational):
//   - inputs addr[1:0], func3, wr_data, ram_rdata
//   - outputs be, wdata, load_ext, misaligned
//   - instantiated once; the FSM, wait counter and output registers live in dmem_ctrl.
// TESTING
// - LW addr=0x010, ram_ack 1 cycle after req, ram_rdata=0xDEADBEEF
//   -> rd_data=0xDEADBEEF; mem_stall high exactly 2 cycles; ram_addr=0x04.
// - LB addr=0x013, rdata=0x80FF0011 -> rd_data=0xFFFFFF80.
//   LBU same address -> 0x00000080. LHU addr=0x012 -> 0x000080FF.
// - SB addr=0x005, wr_data=0x000000AB -> ram_be=0010, ram_wdata=0xABABABAB, ram_we=1.
//   SH addr=0x006 -> ram_be=1100.
// - LW addr=0x006 -> misalign pulse, ram_req never asserts, mem_stall stays 0, rd_data=0.
// - ram_ack withheld -> ram_req drops after TIMEOUT=15 ACCESS cycles, bus_err pulses,
//   mem_stall falls in DONE.
// - Reset asserted in ACCESS -> next cycle all outputs 0 and state IDLE;
//   a late ram_ack causes no rd_data change.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller.
// Holds the controller state type, the func3 access-size codes and a
// small lane-select helper used by the load-extension logic.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Pick one byte lane out of a 32-bit RAM word.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the data-memory controller.
// Ports:
//   i_addr_lo    byte offset within the word (addr[1:0])
//   i_func3      access size / sign code
//   i_wr_data    store data as delivered by the pipeline
//   i_ram_rdata  raw RAM read word
//   o_be         byte enables for the access size and offset
//   o_wdata      store data replicated across lanes
//   o_load_ext   selected and sign/zero-extended load value
//   o_misaligned access does not sit on its natural boundary
module lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_ram_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_ext,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = pick_byte(i_ram_rdata, i_addr_lo);
  assign w_half = i_addr_lo[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];

  // Size decode: any code that is not a byte or half access behaves as a word.
  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wr_data;
    o_load_ext   = i_ram_rdata;
    o_misaligned = 1'b0;
    case (i_func3)
      F3_B, F3_BU: begin
        o_be       = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_wr_data[7:0]}};
        o_load_ext = (i_func3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      end
      F3_H, F3_HU: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wr_data[15:0]}};
        o_load_ext   = (i_func3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_wr_data;
        o_load_ext   = i_ram_rdata;
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory access controller.
// Issues one RAM transaction per load/store, stalls the pipeline until the
// RAM acknowledges (or the wait times out) and returns the extended load data.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   MemRead, MemWrite     request strobes, held while mem_stall is high
//   addr, wr_data, func3  byte address, store data, access size/sign
//   rd_data               extended load result (registered)
//   mem_stall             freezes IF..MEM while the access is outstanding
//   misalign, bus_err     one-cycle pulses for dropped / timed-out accesses
//   ram_*                 word-wide RAM request/response interface
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_stall,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [DM_ADDRESS-3:0] ram_addr,
  output logic [3:0]            ram_be,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_ack
);

  // Last ACCESS cycle index at which a missing ack aborts the transaction.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  dmem_state_e           r_state;
  logic [7:0]            r_cnt;
  logic                  r_is_load;
  logic [DATA_W-1:0]     r_rd_data;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_misalign;
  logic                  r_bus_err;
  logic                  r_req;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [DM_ADDRESS-3:0] r_addr;

  logic                  w_req;
  logic [2:0]            w_f3;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_load_ext;
  logic                  w_misaligned;

  assign w_req = MemRead | MemWrite;

  // Stores only know B/H/W; any other store code falls back to a word access.
  always_comb begin
    if (MemWrite && (func3 != F3_B) && (func3 != F3_H)) begin
      w_f3 = F3_W;
    end else begin
      w_f3 = func3;
    end
  end

  lsu_align u_align (
    .i_addr_lo    (addr[1:0]),
    .i_func3      (w_f3),
    .i_wr_data    (wr_data),
    .i_ram_rdata  (ram_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_ext   (w_load_ext),
    .o_misaligned (w_misaligned)
  );

  // Access FSM with its wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_is_load  <= 1'b0;
      r_rd_data  <= {DATA_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_addr     <= {(DM_ADDRESS-2){1'b0}};
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req && w_misaligned) begin
            r_misalign <= 1'b1;
            r_rd_data  <= {DATA_W{1'b0}};
            r_state    <= IDLE;
          end else if (w_req) begin
            r_req     <= 1'b1;
            r_we      <= MemWrite;
            r_be      <= w_be;
            r_addr    <= addr[DM_ADDRESS-1:2];
            r_wdata   <= MemWrite ? w_wdata : {DATA_W{1'b0}};
            // A simultaneous read+write is a store: no load result.
            r_is_load <= ~MemWrite;
            r_cnt     <= 8'd0;
            r_state   <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          // An ack in the final wait cycle still completes normally.
          if (ram_ack) begin
            if (r_is_load) begin
              r_rd_data <= w_load_ext;
            end else begin
              r_rd_data <= r_rd_data;
            end
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_state <= DONE;
          end else if (r_cnt == TO_LAST) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= 4'b0000;
            r_bus_err <= 1'b1;
            r_rd_data <= {DATA_W{1'b0}};
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          // The held request is never re-issued: one pipeline advance, then idle.
          r_state <= IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_be    <= 4'b0000;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Stall rises combinationally in the launch cycle so the pipeline freezes at once.
  assign mem_stall = ~reset & ((r_state == ACCESS) |
                               ((r_state == IDLE) & w_req & ~w_misaligned));

  assign rd_data   = r_rd_data;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign ram_req   = r_req;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_be    = r_be;
  assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset-in-flight
// sequence and randomized accesses checked against a size/offset reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic [31:0] rd_data;
  logic        mem_stall, misalign, bus_err;
  logic        ram_req, ram_we;
  logic [6:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_ack;

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_stall, obs_req, obs_mis, obs_berr, obs_bound;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [6:0]  obs_wa;
  logic [31:0] obs_wd, obs_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rdat;
    int          ack;
    logic [31:0] e_rd;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [6:0]  e_wa;
    int          e_stall;
    int          e_mis;
    int          e_berr;
  } vec_t;

  vec_t tbl[16];

  dmem_ctrl #(.DATA_W(32), .DM_ADDRESS(9), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wr_data   (wr_data),
    .func3     (func3),
    .rd_data   (rd_data),
    .mem_stall (mem_stall),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_be    (ram_be),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives one request (called just after a rising edge), acts as the RAM
  // (ack after ack_after request cycles; >=15 means never) and records what it sees.
  task automatic run_acc(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic [31:0] rdat, input int ack_after);
    int cyc;
    bit ended;
    obs_stall = 0; obs_req = 0; obs_mis = 0; obs_berr = 0; obs_bound = 0;
    obs_be = 4'h0; obs_we = 1'b0; obs_wa = 7'h00; obs_wd = 32'h0;
    MemRead = rd; MemWrite = wr; addr = a; wr_data = wd; func3 = f3; ram_rdata = rdat;
    ended = 1'b0;
    cyc = 0;
    while (!ended && cyc < 40) begin
      @(negedge clk);
      if (mem_stall) obs_stall++;
      if (misalign) obs_mis++;
      if (bus_err) obs_berr++;
      if (ram_req) begin
        if (obs_req == 0) begin
          obs_be = ram_be; obs_we = ram_we; obs_wa = ram_addr; obs_wd = ram_wdata;
        end
        ram_ack = (obs_req == ack_after);
        obs_req++;
      end else begin
        ram_ack = 1'b0;
      end
      if (!mem_stall) ended = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (!ended) obs_bound = 1;
    MemRead = 1'b0; MemWrite = 1'b0; ram_ack = 1'b0;
    @(negedge clk);
    if (misalign) obs_mis++;
    if (bus_err) obs_berr++;
    obs_rd = rd_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rd wr  addr     wd            f3      rdata         ack  e_rd          e_be    e_wd          e_wa  st mis berr
    tbl[0]  = '{1'b1, 1'b0, 9'h010, 32'h00000000, 3'b010, 32'hDEADBEEF, 0,  32'hDEADBEEF, 4'h0, 32'h00000000, 7'h04, 2,  0, 0};
    tbl[1]  = '{1'b1, 1'b0, 9'h013, 32'h00000000, 3'b000, 32'h80FF0011, 1,  32'hFFFFFF80, 4'h0, 32'h00000000, 7'h04, 3,  0, 0};
    tbl[2]  = '{1'b1, 1'b0, 9'h013, 32'h00000000, 3'b100, 32'h80FF0011, 0,  32'h00000080, 4'h0, 32'h00000000, 7'h04, 2,  0, 0};
    tbl[3]  = '{1'b1, 1'b0, 9'h012, 32'h00000000, 3'b101, 32'h80FF0011, 0,  32'h000080FF, 4'h0, 32'h00000000, 7'h04, 2,  0, 0};
    tbl[4]  = '{1'b1, 1'b0, 9'h012, 32'h00000000, 3'b001, 32'h80FF0011, 2,  32'hFFFF80FF, 4'h0, 32'h00000000, 7'h04, 4,  0, 0};
    tbl[5]  = '{1'b0, 1'b1, 9'h005, 32'h000000AB, 3'b000, 32'h00000000, 0,  32'hFFFF80FF, 4'h2, 32'hABABABAB, 7'h01, 2,  0, 0};
    tbl[6]  = '{1'b0, 1'b1, 9'h006, 32'h0000BEEF, 3'b001, 32'h00000000, 1,  32'hFFFF80FF, 4'hC, 32'hBEEFBEEF, 7'h01, 3,  0, 0};
    tbl[7]  = '{1'b0, 1'b1, 9'h008, 32'h12345678, 3'b010, 32'h00000000, 3,  32'hFFFF80FF, 4'hF, 32'h12345678, 7'h02, 5,  0, 0};
    tbl[8]  = '{1'b1, 1'b0, 9'h006, 32'h00000000, 3'b010, 32'h00000000, 0,  32'h00000000, 4'h0, 32'h00000000, 7'h00, 0,  1, 0};
    tbl[9]  = '{1'b1, 1'b0, 9'h001, 32'h00000000, 3'b000, 32'h00007F00, 0,  32'h0000007F, 4'h0, 32'h00000000, 7'h00, 2,  0, 0};
    tbl[10] = '{1'b1, 1'b0, 9'h014, 32'h00000000, 3'b010, 32'hCAFEF00D, 99, 32'h00000000, 4'h0, 32'h00000000, 7'h05, 16, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 9'h002, 32'h00000000, 3'b101, 32'hABCD0000, 0,  32'h0000ABCD, 4'h0, 32'h00000000, 7'h00, 2,  0, 0};
    tbl[12] = '{1'b1, 1'b1, 9'h00C, 32'h55AA55AA, 3'b010, 32'h11111111, 0,  32'h0000ABCD, 4'hF, 32'h55AA55AA, 7'h03, 2,  0, 0};
    tbl[13] = '{1'b0, 1'b1, 9'h003, 32'h00000001, 3'b001, 32'h00000000, 0,  32'h00000000, 4'h0, 32'h00000000, 7'h00, 0,  1, 0};
    tbl[14] = '{1'b1, 1'b0, 9'h018, 32'h00000000, 3'b111, 32'h87654321, 1,  32'h87654321, 4'h0, 32'h00000000, 7'h06, 3,  0, 0};
    tbl[15] = '{1'b0, 1'b1, 9'h1FF, 32'h0000003C, 3'b000, 32'h00000000, 0,  32'h87654321, 4'h8, 32'h3C3C3C3C, 7'h7F, 2,  0, 0};

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = 9'h000;
    wr_data = 32'h0; func3 = 3'b000; ram_rdata = 32'h0; ram_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_ram_req", {31'h0, ram_req}, 32'h0);
    check("rst_ram_we", {31'h0, ram_we}, 32'h0);
    check("rst_ram_be", {28'h0, ram_be}, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      run_acc(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, tbl[i].rdat, tbl[i].ack);
      check($sformatf("v%0d_bound", i), obs_bound, 0);
      check($sformatf("v%0d_stall", i), obs_stall, tbl[i].e_stall);
      check($sformatf("v%0d_reqcyc", i), obs_req, (tbl[i].e_mis != 0) ? 0 : tbl[i].e_stall - 1);
      check($sformatf("v%0d_misalign", i), obs_mis, tbl[i].e_mis);
      check($sformatf("v%0d_bus_err", i), obs_berr, tbl[i].e_berr);
      check($sformatf("v%0d_rd_data", i), obs_rd, tbl[i].e_rd);
      if (tbl[i].e_mis == 0) begin
        check($sformatf("v%0d_ram_we", i), {31'h0, obs_we}, {31'h0, tbl[i].wr});
        check($sformatf("v%0d_ram_addr", i), {25'h0, obs_wa}, {25'h0, tbl[i].e_wa});
        if (tbl[i].wr) begin
          check($sformatf("v%0d_ram_be", i), {28'h0, obs_be}, {28'h0, tbl[i].e_be});
          check($sformatf("v%0d_ram_wdata", i), obs_wd, tbl[i].e_wd);
        end
      end
    end

    // Reset while the RAM is still being waited on, then a late ack.
    MemRead = 1'b1; MemWrite = 1'b0; addr = 9'h020; func3 = 3'b010; ram_rdata = 32'h13572468;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_req_up", {31'h0, ram_req}, 32'h1);
    reset = 1'b1;
    MemRead = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ram_ack = 1'b1;
    ram_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rst_mid_ram_req", {31'h0, ram_req}, 32'h0);
    check("rst_mid_stall", {31'h0, mem_stall}, 32'h0);
    check("rst_mid_rd_data", rd_data, 32'h0);
    check("rst_mid_ram_be", {28'h0, ram_be}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("late_ack_rd_data", rd_data, 32'h0);
    check("late_ack_ram_req", {31'h0, ram_req}, 32'h0);
    ram_ack = 1'b0;
    @(posedge clk);
    #1;

    // Randomized accesses against a size/offset reference model.
    begin
      logic [31:0] m_rd;
      m_rd = 32'h0;
      for (int n = 0; n < 80; n++) begin
        logic        rd, wr, sgn;
        logic [8:0]  a;
        logic [2:0]  f3;
        logic [31:0] wd, rdat, mask, val, ewd;
        logic [3:0]  ebe;
        int          size, off, ack, r, e_stall;
        bit          req, ld, mis, tmo;
        rd   = 1'($urandom_range(0, 1));
        wr   = 1'($urandom_range(0, 1));
        a    = 9'($urandom);
        f3   = 3'($urandom);
        wd   = $urandom;
        rdat = $urandom;
        r    = $urandom_range(0, 9);
        ack  = (r == 9) ? 99 : r % 4;

        req = rd | wr;
        ld  = rd & ~wr;
        if (wr) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sgn  = (f3 == 3'd0 || f3 == 3'd1);
        off  = int'(a) % 4;
        mis  = req && ((off % size) != 0);
        tmo  = (ack >= 15);
        ebe  = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (rdat >> (8 * off)) & mask;
        if (sgn && size < 4 && val[8*size-1]) val = val | ~mask;

        if (mis) m_rd = 32'h0;
        else if (req && tmo) m_rd = 32'h0;
        else if (req && ld) m_rd = val;
        e_stall = (!req || mis) ? 0 : (tmo ? 16 : ack + 2);

        run_acc(rd, wr, a, wd, f3, rdat, ack);
        check($sformatf("r%0d_bound", n), obs_bound, 0);
        check($sformatf("r%0d_stall", n), obs_stall, e_stall);
        check($sformatf("r%0d_misalign", n), obs_mis, mis ? 1 : 0);
        check($sformatf("r%0d_bus_err", n), obs_berr, (req && !mis && tmo) ? 1 : 0);
        check($sformatf("r%0d_rd_data", n), obs_rd, m_rd);
        if (req && !mis) begin
          check($sformatf("r%0d_ram_we", n), {31'h0, obs_we}, {31'h0, wr});
          check($sformatf("r%0d_ram_addr", n), {25'h0, obs_wa}, {25'h0, a[8:2]});
          if (wr) begin
            check($sformatf("r%0d_ram_be", n), {28'h0, obs_be}, {28'h0, ebe});
            check($sformatf("r%0d_ram_wdata", n), obs_wd, ewd);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
